// File: rtl/lv8_branch_pkg.sv
// Shared encodings for the LEGv8 branch resolver: branch types, condition
// codes, PC-select codes, flag bit positions and the resolver FSM states.
package lv8_branch_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_B    = 3'd1;
  localparam logic [2:0] BR_COND = 3'd2;
  localparam logic [2:0] BR_CBZ  = 3'd3;
  localparam logic [2:0] BR_CBNZ = 3'd4;
  localparam logic [2:0] BR_REG  = 3'd5;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [1:0] PS_INC = 2'b01;
  localparam logic [1:0] PS_REL = 2'b10;
  localparam logic [1:0] PS_REG = 2'b11;

  localparam int unsigned V_IDX = 3;
  localparam int unsigned C_IDX = 2;
  localparam int unsigned Z_IDX = 1;
  localparam int unsigned N_IDX = 0;

  typedef enum logic {
    StIdle,
    StFlush
  } brs_state_e;

  // Types 1..5 count as real branches; 0, 6 and 7 are no-ops.
  function automatic logic is_branch_type(input logic [2:0] t);
    return (t >= BR_B) && (t <= BR_REG);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational LEGv8 condition-code evaluator over {V,C,Z,N} flags.
module cond_eval
  import lv8_branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic v, c, z, n;

  assign v = flags[V_IDX];
  assign c = flags[C_IDX];
  assign z = flags[Z_IDX];
  assign n = flags[N_IDX];

  // Full condition table; AL and NV both always pass.
  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_HS: pass = c;
      COND_LO: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// LEGv8 branch resolver: holds VCZN status, resolves B/B.cond/CBZ/CBNZ/BR with
// one-cycle registered outputs, sequences wrong-path flushes and counts branches.
module branch_resolve_unit
  import lv8_branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned FWD_STATUS   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [2:0]            br_type,
  input  logic [3:0]            cond,
  input  logic [DATA_WIDTH-1:0] reg_val,
  input  logic                  status_load,
  input  logic [3:0]            alu_status,
  output logic                  out_valid,
  output logic                  taken,
  output logic [1:0]            PS,
  output logic                  flush,
  output logic [3:0]            status,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  taken_count
);

  localparam logic [2:0] FcntInit = 3'(FLUSH_CYCLES - 1);

  brs_state_e  state_q;
  logic [2:0]  fcnt_q;
  logic [3:0]  eff_flags;
  logic        cond_pass;
  logic        reg_zero;
  logic        accept;
  logic        take_now;
  logic [1:0]  ps_taken;

  // Bypass lets a branch see flags written in the same cycle.
  assign eff_flags = ((FWD_STATUS != 0) && status_load) ? alu_status : status;
  assign reg_zero  = (reg_val == '0);
  assign accept    = in_valid && (state_q == StIdle);
  assign ps_taken  = (br_type == BR_REG) ? PS_REG : PS_REL;

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (eff_flags),
    .pass  (cond_pass)
  );

  // Taken decision for the branch presented this cycle.
  always_comb begin
    take_now = 1'b0;
    case (br_type)
      BR_B:    take_now = 1'b1;
      BR_REG:  take_now = 1'b1;
      BR_COND: take_now = cond_pass;
      BR_CBZ:  take_now = reg_zero;
      BR_CBNZ: take_now = ~reg_zero;
      default: take_now = 1'b0;
    endcase
  end

  // Resolution outputs and IDLE/FLUSH sequencer; flush rises with taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      fcnt_q    <= 3'd0;
      out_valid <= 1'b0;
      taken     <= 1'b0;
      PS        <= PS_INC;
      flush     <= 1'b0;
    end else begin
      out_valid <= accept;
      taken     <= accept && take_now;
      PS        <= (accept && take_now) ? ps_taken : PS_INC;
      case (state_q)
        StIdle: begin
          if (accept && take_now) begin
            state_q <= StFlush;
            fcnt_q  <= FcntInit;
            flush   <= 1'b1;
          end else begin
            flush   <= 1'b0;
          end
        end
        StFlush: begin
          if (fcnt_q == 3'd0) begin
            state_q <= StIdle;
            flush   <= 1'b0;
          end else begin
            fcnt_q  <= fcnt_q - 3'd1;
            flush   <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          flush   <= 1'b0;
        end
      endcase
    end
  end

  // Status register and saturating performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      status       <= 4'b0000;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (status_load) begin
        status <= alu_status;
      end
      if (accept && is_branch_type(br_type) && (branch_count != '1)) begin
        branch_count <= branch_count + 1'b1;
      end
      if (accept && take_now && (taken_count != '1)) begin
        taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit and its cond_eval sub-block.
module tb_branch_resolve_unit;
  import lv8_branch_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [2:0]  br_type;
  logic [3:0]  cond;
  logic [63:0] reg_val;
  logic        status_load;
  logic [3:0]  alu_status;

  // dut0: defaults (forwarding on, one flush cycle, 16-bit counters)
  logic        o0_valid, o0_taken, o0_flush;
  logic [1:0]  o0_ps;
  logic [3:0]  o0_status;
  logic [15:0] o0_bcnt, o0_tcnt;
  // dut1: no forwarding, three flush cycles
  logic        o1_valid, o1_taken, o1_flush;
  logic [1:0]  o1_ps;
  logic [3:0]  o1_status;
  logic [15:0] o1_bcnt, o1_tcnt;
  // dut2: 2-bit counters
  logic        o2_valid, o2_taken, o2_flush;
  logic [1:0]  o2_ps;
  logic [3:0]  o2_status;
  logic [1:0]  o2_bcnt, o2_tcnt;

  logic [3:0]  ce_cond, ce_flags;
  logic        ce_pass;

  int n_cmp = 0;
  int n_fail = 0;

  branch_resolve_unit u_dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .br_type(br_type), .cond(cond),
    .reg_val(reg_val), .status_load(status_load), .alu_status(alu_status),
    .out_valid(o0_valid), .taken(o0_taken), .PS(o0_ps), .flush(o0_flush),
    .status(o0_status), .branch_count(o0_bcnt), .taken_count(o0_tcnt)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(3), .FWD_STATUS(0)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .br_type(br_type), .cond(cond),
    .reg_val(reg_val), .status_load(status_load), .alu_status(alu_status),
    .out_valid(o1_valid), .taken(o1_taken), .PS(o1_ps), .flush(o1_flush),
    .status(o1_status), .branch_count(o1_bcnt), .taken_count(o1_tcnt)
  );

  branch_resolve_unit #(.CNT_WIDTH(2), .FLUSH_CYCLES(1)) u_dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .br_type(br_type), .cond(cond),
    .reg_val(reg_val), .status_load(status_load), .alu_status(alu_status),
    .out_valid(o2_valid), .taken(o2_taken), .PS(o2_ps), .flush(o2_flush),
    .status(o2_status), .branch_count(o2_bcnt), .taken_count(o2_tcnt)
  );

  cond_eval u_ce (
    .cond  (ce_cond),
    .flags (ce_flags),
    .pass  (ce_pass)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [2:0]  bt;
    logic [3:0]  cd;
    logic [63:0] rv;
    logic        sl;
    logic [3:0]  as;
    logic        e_valid;
    logic        e_taken;
    logic [1:0]  e_ps;
    logic        e_flush;
    logic [3:0]  e_status;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; br_type = BR_NONE; cond = 4'h0; reg_val = 64'd0;
    status_load = 1'b0; alu_status = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Condition model built from the base-condition/invert-bit structure.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic v, cy, z, n, base;
    v = f[3]; cy = f[2]; z = f[1]; n = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  initial begin
    int exp_b, exp_t;

    // iv bt cd rv sl as | valid taken ps flush status
    vecs[0]  = '{1'b1, BR_COND, COND_EQ, 64'd0, 1'b1, 4'b0010, 1'b1, 1'b1, PS_REL, 1'b1, 4'b0010};
    vecs[1]  = '{1'b1, BR_COND, COND_NE, 64'd0, 1'b0, 4'b0000, 1'b1, 1'b0, PS_INC, 1'b0, 4'b0010};
    vecs[2]  = '{1'b1, BR_COND, COND_GE, 64'd0, 1'b1, 4'b1001, 1'b1, 1'b1, PS_REL, 1'b1, 4'b1001};
    vecs[3]  = '{1'b1, BR_COND, COND_LT, 64'd0, 1'b0, 4'b0000, 1'b1, 1'b0, PS_INC, 1'b0, 4'b1001};
    vecs[4]  = '{1'b1, BR_CBZ,  4'h0,    64'd0, 1'b0, 4'b0000, 1'b1, 1'b1, PS_REL, 1'b1, 4'b1001};
    vecs[5]  = '{1'b1, BR_CBNZ, 4'h0,    64'd5, 1'b0, 4'b0000, 1'b1, 1'b1, PS_REL, 1'b1, 4'b1001};
    vecs[6]  = '{1'b1, BR_CBZ,  4'h0,    64'h8000_0000_0000_0000, 1'b0, 4'b0000,
                 1'b1, 1'b0, PS_INC, 1'b0, 4'b1001};
    vecs[7]  = '{1'b1, BR_REG,  4'h0,    64'd0, 1'b0, 4'b0000, 1'b1, 1'b1, PS_REG, 1'b1, 4'b1001};
    vecs[8]  = '{1'b1, BR_NONE, 4'h0,    64'd0, 1'b0, 4'b0000, 1'b1, 1'b0, PS_INC, 1'b0, 4'b1001};
    vecs[9]  = '{1'b1, 3'd7,    4'h0,    64'd0, 1'b0, 4'b0000, 1'b1, 1'b0, PS_INC, 1'b0, 4'b1001};
    vecs[10] = '{1'b0, BR_REG,  4'h0,    64'd0, 1'b0, 4'b0000, 1'b0, 1'b0, PS_INC, 1'b0, 4'b1001};
    vecs[11] = '{1'b1, BR_COND, COND_HI, 64'd0, 1'b1, 4'b0100, 1'b1, 1'b1, PS_REL, 1'b1, 4'b0100};
    vecs[12] = '{1'b1, BR_COND, COND_LS, 64'd0, 1'b1, 4'b0110, 1'b1, 1'b1, PS_REL, 1'b1, 4'b0110};
    vecs[13] = '{1'b0, BR_NONE, 4'h0,    64'd0, 1'b1, 4'b0000, 1'b0, 1'b0, PS_INC, 1'b0, 4'b0000};
    vecs[14] = '{1'b1, BR_COND, COND_NV, 64'd0, 1'b0, 4'b0000, 1'b1, 1'b1, PS_REL, 1'b1, 4'b0000};
    vecs[15] = '{1'b1, BR_COND, COND_GT, 64'd0, 1'b0, 4'b0000, 1'b1, 1'b1, PS_REL, 1'b1, 4'b0000};
    vecs[16] = '{1'b1, BR_COND, COND_VS, 64'd0, 1'b0, 4'b0000, 1'b1, 1'b0, PS_INC, 1'b0, 4'b0000};

    // Reset while every input toggles; values must hold one more cycle.
    reset = 1'b1; in_valid = 1'b1; br_type = BR_B; cond = 4'hE; reg_val = '1;
    status_load = 1'b1; alu_status = 4'hF;
    tick();
    chk("rst_valid", o0_valid, 1'b0);
    chk("rst_taken", o0_taken, 1'b0);
    chk("rst_ps", o0_ps, PS_INC);
    chk("rst_flush", o0_flush, 1'b0);
    chk("rst_status", o0_status, 4'h0);
    chk("rst_bcnt", o0_bcnt, 16'd0);
    chk("rst_tcnt", o0_tcnt, 16'd0);
    in_valid = 1'b0; br_type = BR_REG; alu_status = 4'hA;
    tick();
    chk("rst2_ps", o0_ps, PS_INC);
    chk("rst2_status", o0_status, 4'h0);
    reset = 1'b0;
    idle_inputs();
    tick();
    chk("post_rst_ps", o0_ps, PS_INC);
    chk("post_rst_status", o0_status, 4'h0);
    chk("post_rst_bcnt", o0_bcnt, 16'd0);
    chk("post_rst_flush", o0_flush, 1'b0);

    // Table vectors on dut0, each followed by an idle cycle to clear flush.
    exp_b = 0; exp_t = 0;
    for (int i = 0; i < 17; i++) begin
      in_valid = vecs[i].iv; br_type = vecs[i].bt; cond = vecs[i].cd;
      reg_val = vecs[i].rv; status_load = vecs[i].sl; alu_status = vecs[i].as;
      if (vecs[i].iv && vecs[i].bt >= 3'd1 && vecs[i].bt <= 3'd5) exp_b++;
      if (vecs[i].e_taken) exp_t++;
      tick();
      chk($sformatf("v%0d_valid", i), o0_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_taken", i), o0_taken, vecs[i].e_taken);
      chk($sformatf("v%0d_ps", i), o0_ps, vecs[i].e_ps);
      chk($sformatf("v%0d_flush", i), o0_flush, vecs[i].e_flush);
      chk($sformatf("v%0d_status", i), o0_status, vecs[i].e_status);
      idle_inputs();
      tick();
      chk($sformatf("v%0d_idle_flush", i), o0_flush, 1'b0);
      chk($sformatf("v%0d_idle_valid", i), o0_valid, 1'b0);
    end
    chk("tbl_bcnt", o0_bcnt, 64'(exp_b));
    chk("tbl_tcnt", o0_tcnt, 64'(exp_t));

    // Same-cycle flag load: bypassed on dut0, previous flags on dut1.
    do_reset();
    status_load = 1'b1; alu_status = 4'b0001;
    tick();
    status_load = 1'b1; alu_status = 4'b1001;
    in_valid = 1'b1; br_type = BR_COND; cond = COND_GE;
    tick();
    chk("fwd1_taken", o0_taken, 1'b1);
    chk("fwd1_flush", o0_flush, 1'b1);
    chk("fwd0_taken", o1_taken, 1'b0);
    chk("fwd0_valid", o1_valid, 1'b1);
    chk("fwd0_flush", o1_flush, 1'b0);
    chk("fwd0_status", o1_status, 4'b1001);
    idle_inputs();
    tick();

    // Three-cycle flush on dut1 squashes the following branches.
    do_reset();
    in_valid = 1'b1; br_type = BR_REG;
    tick();
    chk("fc3_ps", o1_ps, PS_REG);
    chk("fc3_taken", o1_taken, 1'b1);
    chk("fc3_flush0", o1_flush, 1'b1);
    br_type = BR_B;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("fc3_sq%0d_valid", k), o1_valid, 1'b0);
      chk($sformatf("fc3_sq%0d_flush", k), o1_flush, (k < 3) ? 1'b1 : 1'b0);
    end
    idle_inputs();
    chk("fc3_bcnt", o1_bcnt, 16'd1);
    chk("fc3_tcnt", o1_tcnt, 16'd1);

    // Status loads during flush; reset mid-flush aborts it.
    in_valid = 1'b1; br_type = BR_B;
    tick();
    in_valid = 1'b0; status_load = 1'b1; alu_status = 4'b1100;
    tick();
    chk("flush_status_ld", o1_status, 4'b1100);
    chk("flush_still", o1_flush, 1'b1);
    reset = 1'b1; status_load = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_mid_flush", o1_flush, 1'b0);
    chk("rst_mid_status", o1_status, 4'h0);
    tick();
    chk("rst_mid_flush2", o1_flush, 1'b0);

    // Back-to-back CBNZ/CBZ on zero operand.
    do_reset();
    in_valid = 1'b1; br_type = BR_CBNZ; reg_val = 64'd0;
    tick();
    chk("b2b0_valid", o0_valid, 1'b1);
    chk("b2b0_taken", o0_taken, 1'b0);
    chk("b2b0_ps", o0_ps, PS_INC);
    br_type = BR_CBZ;
    tick();
    chk("b2b1_valid", o0_valid, 1'b1);
    chk("b2b1_taken", o0_taken, 1'b1);
    chk("b2b1_ps", o0_ps, PS_REL);
    idle_inputs();
    tick();

    // Counter saturation on dut2 with five spaced taken branches.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; br_type = BR_B;
      tick();
      chk($sformatf("sat%0d_taken", k), o2_taken, 1'b1);
      in_valid = 1'b0;
      tick();
    end
    chk("sat_tcnt", o2_tcnt, 2'd3);
    chk("sat_bcnt", o2_bcnt, 2'd3);

    // Exhaustive condition evaluator sweep.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        ce_cond = 4'(c); ce_flags = 4'(f);
        #1;
        chk($sformatf("ce_c%0h_f%0h", c, f), ce_pass, cond_model(4'(c), 4'(f)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
